vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the VGA output path. Walks a horizontal/vertical pixel counter over the full frame, including the blanking intervals. Produces the `pixel_x`/`pixel_y` coordinates consumed by the pixel-colour stage. Produces the active-low sync pulses and blank flag driven to the DAC/connector alongside that stage's RGB outputs. Default timing is 640x480 at 60 Hz from a 25 MHz pixel tick.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (ticks)
- `H_SYNC`, 96, hsync pulse width (ticks)
- `H_BP`, 48, horizontal back porch (ticks)
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `clk` input 1 system clock; all state on rising edge
- `rst` input 1 asynchronous, active-low reset
- `pixel_x` output 10 horizontal position of the current tick, 0..H_TOTAL-1
- `pixel_y` output 10 vertical position of the current tick, 0..V_TOTAL-1
- `hsync_n` output 1 horizontal sync, active low
- `vsync_n` output 1 vertical sync, active low
- `blank` output 1 high when the position is outside the visible area
- `frame_start` output 1 one-clk pulse when the position wraps to (0,0)
- `pixel_ce` output 1 high on the clk cycles where the position advances (tick)

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
- Constraint: both totals must be ≤1024. Behaviour outside this range is undefined; no check is made.
- h counter: on each tick, increments; at H_TOTAL-1 it wraps to 0.
- v counter: advances only on an h wrap; at V_TOTAL-1 it wraps to 0.
- Outputs `pixel_x`/`pixel_y` equal the h/v counters.
- `blank` = (x ≥ H_VISIBLE) or (y ≥ V_VISIBLE).
- `hsync_n` = 0 iff H_VISIBLE+H_FP ≤ x < H_VISIBLE+H_FP+H_SYNC (default 656..751). This applies on every line, including vertical blanking lines.
- `vsync_n` = 0 iff V_VISIBLE+V_FP ≤ y < V_VISIBLE+V_FP+V_SYNC (default 490..491), for the whole line.
- `frame_start` = 1 for exactly one clk cycle, on the first cycle the outputs show (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - It is not asserted for the (0,0) position produced by reset.
- All outputs are flops, mutually aligned: `hsync_n`, `vsync_n`, `blank` and `frame_start` always describe the same (x,y) currently shown on `pixel_x`/`pixel_y`.
  - No output lags another.
  - Decode is performed on next-state values.
- Reset values (asynchronous, while `rst`=0):
  - `pixel_x`=0, `pixel_y`=0, `blank`=0, `hsync_n`=1, `vsync_n`=1, `frame_start`=0.
  - `pixel_ce`=0; the divider toggle is also cleared (see Configuration).
- Reset mid-frame: all outputs return to their reset values immediately. After reset is released, the position restarts at (0,0) with no `frame_start` pulse.

## Timing
- Without the divider, a tick occurs on every clk cycle. The first advance is on the first rising edge after `rst` deasserts: (0,0) becomes (1,0).
- The output change is visible in the same cycle that the tick edge occurs; there is no extra pipeline latency.
- Line period: H_TOTAL ticks. Frame period: H_TOTAL×V_TOTAL ticks (default 420000).
- Downstream colour stages must compensate for their own latency. This block provides no delayed sync outputs.

## Configuration
- Macro: `VGA_TIMING_CLKDIV2_EN`.
- Defined:
  - An internal toggle flop, reset to 0, inverts on every clk cycle.
  - A tick occurs only on cycles where the toggle is 1, so the position advances every second clk. This targets a 50 MHz board clock with a 25 MHz pixel rate.
  - `pixel_ce` = toggle, so it is high one cycle in two.
  - Outputs hold their values between ticks.
  - `frame_start` is asserted for exactly one clk cycle: the first cycle showing (0,0).
  - The first advance happens on the second rising edge after reset release.
- Undefined: no toggle flop; `pixel_ce` is held at 1 outside reset; a tick occurs every clk.

## Test plan
- Reset: hold `rst`=0 for 5 cycles, then release.
  - Required: during reset, all outputs at their reset values.
  - Required: outputs are (1,0) one cycle after release.
  - Required: no `frame_start` pulse within the first 419999 ticks.
- Line timing: measure the interval between consecutive `hsync_n` falling edges.
  - Required: 800 ticks apart.
  - Required: the falling edge occurs at `pixel_x`=656 and the rising edge at `pixel_x`=752.
  - Required: `blank` rises at `pixel_x`=640 and falls at `pixel_x`=0 on lines 1..479.
- Frame timing: check vsync, blank and frame_start over a full frame.
  - Required: `vsync_n` is low exactly for `pixel_y`=490..491 (1600 ticks).
  - Required: `blank`=1 for every x on lines 480..524.
  - Required: `frame_start` pulses are 420000 ticks apart, each coincident with (0,0).
- Wrap boundary: observe the position across the end of the frame.
  - Required: at (799,524) the next tick gives (0,0) with `frame_start`=1 and `blank`=0.
  - Required: at (799,100) the next tick gives (0,101).
- Mid-frame reset: assert `rst`=0 at (300,200) for 1 cycle.
  - Required: outputs immediately return to their reset values.
  - Required: after release, counting resumes from (0,0), with no `frame_start` pulse.
- With `VGA_TIMING_CLKDIV2_EN`:
  - Required: `pixel_ce` alternates 0,1 starting at 0 after reset.
  - Required: `hsync_n` falling edges are 1600 clk cycles apart.
  - Required: each `frame_start` pulse lasts exactly 1 clk cycle.
  - Required: frame period is 840000 clk cycles.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel position, active-low syncs, blank and frame-start flags.
// Optional macro VGA_TIMING_CLKDIV2_EN halves the tick rate (50 MHz clk -> 25 MHz pixel tick).
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank,
  output logic       frame_start,
  output logic       pixel_ce
);

  localparam int unsigned CW       = 10;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          blank_q, blank_d;
  logic          hsync_n_q, hsync_n_d;
  logic          vsync_n_q, vsync_n_d;
  logic          frame_start_q, frame_start_d;
  logic          pixel_ce_q, pixel_ce_d;
  logic          tick_c;

  // With the divider, pixel_ce_q is the toggle flop and gates the tick.
`ifdef VGA_TIMING_CLKDIV2_EN
  assign pixel_ce_d = ~pixel_ce_q;
  assign tick_c     = pixel_ce_q;
`else
  assign pixel_ce_d = 1'b1;
  assign tick_c     = 1'b1;
`endif

  // Next position, then decode flags from it so every output shows the same (x,y).
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    if (tick_c) begin
      if (32'(h_q) == H_TOTAL - 1) begin
        h_d = '0;
        if (32'(v_q) == V_TOTAL - 1) begin
          v_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end
    blank_d   = (32'(h_d) >= H_VISIBLE) || (32'(v_d) >= V_VISIBLE);
    hsync_n_d = !((32'(h_d) >= HS_START) && (32'(h_d) < HS_END));
    vsync_n_d = !((32'(v_d) >= VS_START) && (32'(v_d) < VS_END));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q           <= '0;
      v_q           <= '0;
      blank_q       <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
      pixel_ce_q    <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      blank_q       <= blank_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
      pixel_ce_q    <= pixel_ce_d;
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign pixel_ce    = pixel_ce_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance for line checks, reduced-timing instance
// (32x17 frame) so full frames, vsync and frame wrap fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_CLKDIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVV = 480, DVF = 10, DVS = 2,  DVB = 33;
  localparam int SHV = 16,  SHF = 4,  SHS = 6,  SHB = 6;
  localparam int SVV = 10,  SVF = 2,  SVS = 2,  SVB = 3;
  localparam int DHT = DHV + DHF + DHS + DHB;  // 800
  localparam int DVT = DVV + DVF + DVS + DVB;  // 525
  localparam int SHT = SHV + SHF + SHS + SHB;  // 32
  localparam int SVT = SVV + SVF + SVS + SVB;  // 17

  logic       clk, rst;
  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_hs, d_vs, d_bl, d_fs, d_ce;
  logic       s_hs, s_vs, s_bl, s_fs, s_ce;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .pixel_x(d_x), .pixel_y(d_y), .hsync_n(d_hs), .vsync_n(d_vs),
    .blank(d_bl), .frame_start(d_fs), .pixel_ce(d_ce)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .clk(clk), .rst(rst), .pixel_x(s_x), .pixel_y(s_y), .hsync_n(s_hs), .vsync_n(s_vs),
    .blank(s_bl), .frame_start(s_fs), .pixel_ce(s_ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference position model for both instances.
  int   xd, yd, xs, ys;
  logic fsd, fss, ce_m, tog;

  // Event bookkeeping.
  logic prev_d_hs, prev_d_bl, prev_s_vs, prev_s_fs;
  int   last_hs_fall, last_fs, vs_fall_c;
  int   n_hs, n_bf, n_vs, n_fs;

  task automatic chk(input string tag, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int e_blank(input int x, input int y, input int hv, input int vv);
    return (x >= hv || y >= vv) ? 1 : 0;
  endfunction

  function automatic int e_sync_n(input int p, input int start, input int len);
    return (p >= start && p < start + len) ? 0 : 1;
  endfunction

  task automatic model_reset();
    xd = 0; yd = 0; xs = 0; ys = 0;
    fsd = 1'b0; fss = 1'b0; ce_m = 1'b0; tog = 1'b0;
  endtask

  task automatic adv(input int ht, input int vt, inout int x, inout int y, output logic fs);
    fs = (x == ht - 1 && y == vt - 1);
    if (x == ht - 1) begin
      x = 0;
      y = (y == vt - 1) ? 0 : y + 1;
    end else begin
      x = x + 1;
    end
  endtask

  task automatic model_step();
    logic tick;
`ifdef VGA_TIMING_CLKDIV2_EN
    tick = tog;
    tog  = ~tog;
    ce_m = tog;
`else
    tick = 1'b1;
    ce_m = 1'b1;
`endif
    if (tick) begin
      adv(DHT, DVT, xd, yd, fsd);
      adv(SHT, SVT, xs, ys, fss);
    end else begin
      fsd = 1'b0;
      fss = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("d_x",  32'(d_x),  xd);
    chk("d_y",  32'(d_y),  yd);
    chk("d_blank", 32'(d_bl), e_blank(xd, yd, DHV, DVV));
    chk("d_hsync_n", 32'(d_hs), e_sync_n(xd, DHV + DHF, DHS));
    chk("d_vsync_n", 32'(d_vs), e_sync_n(yd, DVV + DVF, DVS));
    chk("d_frame_start", 32'(d_fs), 32'(fsd));
    chk("d_pixel_ce", 32'(d_ce), 32'(ce_m));
    chk("s_x",  32'(s_x),  xs);
    chk("s_y",  32'(s_y),  ys);
    chk("s_blank", 32'(s_bl), e_blank(xs, ys, SHV, SVV));
    chk("s_hsync_n", 32'(s_hs), e_sync_n(xs, SHV + SHF, SHS));
    chk("s_vsync_n", 32'(s_vs), e_sync_n(ys, SVV + SVF, SVS));
    chk("s_frame_start", 32'(s_fs), 32'(fss));
    chk("s_pixel_ce", 32'(s_ce), 32'(ce_m));
  endtask

  // Directed edge checks with hand-computed positions and intervals.
  task automatic events(input int c);
    if (c == DIV) chk("first_adv_x", 32'(d_x), 1);
    if (prev_d_hs && !d_hs) begin
      chk("hs_fall_x", 32'(d_x), 656);
      if (n_hs > 0) chk("hs_period", c - last_hs_fall, 800 * DIV);
      last_hs_fall = c;
      n_hs++;
    end
    if (!prev_d_hs && d_hs) chk("hs_rise_x", 32'(d_x), 752);
    if (!prev_d_bl && d_bl) chk("blank_rise_x", 32'(d_x), 640);
    if (prev_d_bl && !d_bl) begin
      n_bf++;
      chk("blank_fall_x", 32'(d_x), 0);
      chk("blank_fall_y", 32'(d_y), n_bf);
    end
    if (prev_s_vs && !s_vs) begin
      chk("vs_fall_y", 32'(s_y), 12);
      vs_fall_c = c;
      n_vs++;
    end
    if (!prev_s_vs && s_vs) chk("vs_low_len", c - vs_fall_c, 64 * DIV);
    if (prev_s_fs) chk("fs_width", 32'(s_fs), 0);
    if (s_fs) begin
      chk("fs_x", 32'(s_x), 0);
      chk("fs_y", 32'(s_y), 0);
      chk("fs_blank", 32'(s_bl), 0);
      if (n_fs > 0) chk("fs_period", c - last_fs, 544 * DIV);
      else          chk("fs_first", c, 544 * DIV);
      last_fs = c;
      n_fs++;
    end
    prev_d_hs = d_hs;
    prev_d_bl = d_bl;
    prev_s_vs = s_vs;
    prev_s_fs = s_fs;
  endtask

  initial begin
    logic found;
    rst = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_all();

    prev_d_hs = 1'b1; prev_d_bl = 1'b0; prev_s_vs = 1'b1; prev_s_fs = 1'b0;
    last_hs_fall = 0; last_fs = 0; vs_fall_c = 0;
    n_hs = 0; n_bf = 0; n_vs = 0; n_fs = 0;
    rst = 1'b1;
    for (int c = 1; c <= 2000 * DIV; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
      events(c);
    end
    chk("hs_fall_count", n_hs, 2);
    chk("blank_fall_count", n_bf, 2);
    chk("vs_fall_count", n_vs, 3);
    chk("fs_count", n_fs, 3);

    // Walk the small instance to (10,5), then pulse reset mid-frame.
    found = 1'b0;
    for (int c = 0; c < 600 * DIV && !found; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
      if (s_x == 10'd10 && s_y == 10'd5) found = 1'b1;
    end
    chk("midframe_found", 32'(found), 1);

    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;
    for (int c = 1; c <= 100 * DIV; c++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
      if (c == DIV) chk("restart_x", 32'(s_x), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
